// File: rtl/fifo_flow_fsm.sv
// Flow-control supervisor for one main FIFO plus NUM_VC VC and NUM_D destination FIFOs.
// Captures per-FIFO thresholds during INIT and tracks IDLE/ACTIVE/ERROR status.

module fifo_flow_thr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q <= '0;
    else if (load) q <= d;
  end
endmodule

module fifo_flow_fsm #(
  parameter int NUM_VC = 2,
  parameter int NUM_D  = 2,
  parameter int UMB_W  = 4,
  localparam int N_FIFO = 1 + NUM_VC + NUM_D
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [UMB_W-1:0]        umbral_mf_in,
  input  logic [NUM_VC*UMB_W-1:0] umbral_vc_in,
  input  logic [NUM_D*UMB_W-1:0]  umbral_d_in,
  input  logic [N_FIFO-1:0]       fifo_empty,
  input  logic [N_FIFO-1:0]       fifo_error,
  output logic [UMB_W-1:0]        umbral_mf_out,
  output logic [NUM_VC*UMB_W-1:0] umbral_vc_out,
  output logic [NUM_D*UMB_W-1:0]  umbral_d_out,
  output logic [2:0]              state,
  output logic                    idle_out,
  output logic                    active_out,
  output logic                    error_out,
  output logic [N_FIFO-1:0]       error_src
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   load_thr, latch_err;
  logic   any_err, all_empty;

  assign any_err   = |fifo_error;
  assign all_empty = &fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      error_src <= '0;
    end else begin
      state_q <= state_d;
      if (latch_err) error_src <= fifo_error;
    end
  end

  // Error outranks init, which outranks the empty test; ERROR only leaves via reset.
  always_comb begin
    state_d   = state_q;
    load_thr  = 1'b0;
    latch_err = 1'b0;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (init) load_thr = 1'b1;
        else      state_d  = S_IDLE;
      end
      S_IDLE: begin
        if (any_err) begin
          state_d   = S_ERROR;
          latch_err = 1'b1;
        end else if (init)       state_d = S_INIT;
        else if (!all_empty)     state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_err) begin
          state_d   = S_ERROR;
          latch_err = 1'b1;
        end else if (init)       state_d = S_INIT;
        else if (all_empty)      state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  fifo_flow_thr #(.W(UMB_W)) u_thr_mf (
    .clk(clk), .reset(reset), .load(load_thr), .d(umbral_mf_in), .q(umbral_mf_out)
  );

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    fifo_flow_thr #(.W(UMB_W)) u_thr (
      .clk(clk), .reset(reset), .load(load_thr),
      .d(umbral_vc_in[i*UMB_W +: UMB_W]), .q(umbral_vc_out[i*UMB_W +: UMB_W])
    );
  end

  for (genvar i = 0; i < NUM_D; i++) begin : g_d
    fifo_flow_thr #(.W(UMB_W)) u_thr (
      .clk(clk), .reset(reset), .load(load_thr),
      .d(umbral_d_in[i*UMB_W +: UMB_W]), .q(umbral_d_out[i*UMB_W +: UMB_W])
    );
  end

  assign state      = state_q;
  assign idle_out   = (state_q == S_IDLE);
  assign active_out = (state_q == S_ACTIVE);
  assign error_out  = (state_q == S_ERROR);

endmodule

// File: tb/tb_fifo_flow_fsm.sv
// Two configurations (2/2/4 and 4/3/5) driven in lockstep from one stimulus stream
// and compared against a rule-level model of the supervisor.

module tb_fifo_flow_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [7:0]  mf_in;
  logic [63:0] vc_in, d_in;
  logic [7:0]  empty, err;

  logic [3:0]  a_mf;  logic [7:0]  a_vc, a_d;  logic [2:0] a_st;
  logic        a_idle, a_act, a_err;           logic [4:0] a_src;
  logic [4:0]  b_mf;  logic [19:0] b_vc;       logic [14:0] b_d; logic [2:0] b_st;
  logic        b_idle, b_act, b_err;           logic [7:0] b_src;

  int total = 0;
  int bad   = 0;

  // Model: abstract state number, captured thresholds and error snapshot per config.
  int          m_st  [2];
  logic [63:0] m_mf  [2], m_vc [2], m_d [2], m_src [2];
  int          nf    [2] = '{5, 8};
  int          uw    [2] = '{4, 5};
  int          nvc   [2] = '{2, 4};
  int          nd    [2] = '{2, 3};

  always #5 clk = ~clk;

  fifo_flow_fsm #(.NUM_VC(2), .NUM_D(2), .UMB_W(4)) dut_a (
    .clk(clk), .reset(reset), .init(init),
    .umbral_mf_in(mf_in[3:0]), .umbral_vc_in(vc_in[7:0]), .umbral_d_in(d_in[7:0]),
    .fifo_empty(empty[4:0]), .fifo_error(err[4:0]),
    .umbral_mf_out(a_mf), .umbral_vc_out(a_vc), .umbral_d_out(a_d),
    .state(a_st), .idle_out(a_idle), .active_out(a_act), .error_out(a_err),
    .error_src(a_src)
  );

  fifo_flow_fsm #(.NUM_VC(4), .NUM_D(3), .UMB_W(5)) dut_b (
    .clk(clk), .reset(reset), .init(init),
    .umbral_mf_in(mf_in[4:0]), .umbral_vc_in(vc_in[19:0]), .umbral_d_in(d_in[14:0]),
    .fifo_empty(empty), .fifo_error(err),
    .umbral_mf_out(b_mf), .umbral_vc_out(b_vc), .umbral_d_out(b_d),
    .state(b_st), .idle_out(b_idle), .active_out(b_act), .error_out(b_err),
    .error_src(b_src)
  );

  function automatic logic [63:0] msk(input int n);
    return (64'h1 << n) - 64'h1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_rst();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_mf[k] = 0; m_vc[k] = 0; m_d[k] = 0; m_src[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      logic [63:0] m;
      logic ae, ee;
      m  = msk(nf[k]);
      ee = ((err & m) != 0);
      ae = ((empty & m) == m);
      case (m_st[k])
        0: m_st[k] = 1;
        1: if (init) begin
             m_mf[k] = mf_in & msk(uw[k]);
             m_vc[k] = vc_in & msk(uw[k] * nvc[k]);
             m_d[k]  = d_in  & msk(uw[k] * nd[k]);
           end else m_st[k] = 2;
        2, 3: if (ee) begin
             m_st[k] = 4; m_src[k] = err & m;
           end else if (init) m_st[k] = 1;
           else if (m_st[k] == 2 && !ae) m_st[k] = 3;
           else if (m_st[k] == 3 && ae)  m_st[k] = 2;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk("a_state", a_st, m_st[0]);
    chk("a_flags", {a_idle, a_act, a_err},
        {m_st[0] == 2, m_st[0] == 3, m_st[0] == 4});
    chk("a_src", a_src, m_src[0]);
    chk("a_thr", {a_mf, a_vc, a_d}, {m_mf[0][3:0], m_vc[0][7:0], m_d[0][7:0]});
    chk("b_state", b_st, m_st[1]);
    chk("b_flags", {b_idle, b_act, b_err},
        {m_st[1] == 2, m_st[1] == 3, m_st[1] == 4});
    chk("b_src", b_src, m_src[1]);
    chk("b_thr", {b_mf, b_vc, b_d}, {m_mf[1][4:0], m_vc[1][19:0], m_d[1][14:0]});
  endtask

  // Called at a negedge: inputs settle, model and DUT advance on the posedge, check at next negedge.
  task automatic cyc(input logic i, input logic [7:0] e, input logic [7:0] er);
    init = i; empty = e; err = er;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  // Reset raised between edges; outputs must clear before any clock edge arrives.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 model_rst();
    check_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    reset = 1'b0;
  endtask

  task automatic boot();
    cyc(1'b0, 8'hff, 8'h00);
    cyc(1'b0, 8'hff, 8'h00);
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; empty = 8'hff; err = 8'h00;
    mf_in = 8'h06; vc_in = 64'h35; d_in = 64'h27;
    model_rst();
    @(negedge clk);
    check_all();
    chk("rst_state", a_st, 0);
    @(negedge clk);
    reset = 1'b0;

    // Boot, capture thresholds over two init cycles, drop to IDLE.
    cyc(1'b1, 8'hff, 8'h00);
    chk("plan_init", a_st, 1);
    cyc(1'b1, 8'hff, 8'h00);
    cyc(1'b1, 8'hff, 8'h00);
    cyc(1'b0, 8'hff, 8'h00);
    chk("plan_idle", {a_st, a_idle}, {3'd2, 1'b1});
    chk("plan_thr", {a_mf, a_vc, a_d}, {4'h6, 8'h35, 8'h27});

    cyc(1'b0, 8'hfb, 8'h00);
    chk("plan_active", {a_st, a_act, a_idle}, {3'd3, 1'b1, 1'b0});
    cyc(1'b0, 8'hff, 8'h00);
    chk("plan_back_idle", a_st, 2);
    cyc(1'b0, 8'hfb, 8'h00);
    cyc(1'b0, 8'hfb, 8'h04);
    chk("plan_err_src", {a_st, a_err, a_src}, {3'd4, 1'b1, 5'b00100});
    cyc(1'b1, 8'hfb, 8'h01);
    cyc(1'b0, 8'hff, 8'h00);
    chk("plan_err_sticky", {a_st, a_src}, {3'd4, 5'b00100});

    // Error beats init on the same edge.
    do_reset();
    boot();
    cyc(1'b1, 8'hff, 8'h10);
    chk("plan_err_over_init", {a_st, a_src}, {3'd4, 5'b10000});

    // Re-entering INIT keeps old thresholds until the capture edge.
    do_reset();
    mf_in = 8'h0a; vc_in = 64'h9c; d_in = 64'he1;
    cyc(1'b1, 8'hff, 8'h00);
    cyc(1'b1, 8'hff, 8'h00);
    cyc(1'b0, 8'hff, 8'h00);
    mf_in = 8'h03; vc_in = 64'hfedcb; d_in = 64'h4321;
    cyc(1'b1, 8'hff, 8'h00);
    chk("plan_reinit_hold", {a_st, a_mf}, {3'd1, 4'ha});
    cyc(1'b1, 8'hff, 8'h00);
    chk("plan_reinit_cap", a_mf, 4'h3);
    chk("plan_b_lanes", {b_vc, b_d}, {20'hfedcb, 15'h4321});
    cyc(1'b0, 8'hff, 8'h00);
    cyc(1'b0, 8'h7e, 8'h00);

    // Reset mid-ACTIVE, then a D2 error only visible to the 8-FIFO config.
    do_reset();
    boot();
    cyc(1'b0, 8'hff, 8'h80);
    chk("plan_b_d2_err", {b_st, b_src}, {3'd4, 8'h80});
    chk("plan_a_ignores", a_st, 2);

    // Randomized run with rare errors and occasional resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      mf_in = 8'($urandom); vc_in = {$urandom, $urandom}; d_in = {$urandom, $urandom};
      if ($urandom_range(0, 59) == 0) do_reset();
      else cyc(($urandom_range(0, 5) == 0),
               ($urandom_range(0, 1) == 0) ? 8'hff : 8'($urandom),
               ($urandom_range(0, 39) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
